// File: rtl/commit_stage.sv
// commit_stage: retires results to the register files and serialises trap entry/return with the CSR unit
module commit_stage #(
    parameter int XLEN    = 32,
    parameter int FLEN    = 64,
    parameter int CAUSE_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [31:0]        in_insn,
    input  logic [4:0]         in_rd,
    input  logic               in_int_we,
    input  logic [XLEN-1:0]    in_int_value,
    input  logic               in_fp_we,
    input  logic [FLEN-1:0]    in_fp_value,
    input  logic               in_trap_valid,
    input  logic               in_trap_is_interrupt,
    input  logic [CAUSE_W-1:0] in_trap_code,
    input  logic [XLEN-1:0]    in_trap_value,
    input  logic               in_trap_return,
    input  logic               csr_trap_ack,
    input  logic [XLEN-1:0]    csr_trap_target,
    output logic               int_rf_we,
    output logic [4:0]         int_rf_addr,
    output logic [XLEN-1:0]    int_rf_data,
    output logic               fp_rf_we,
    output logic [4:0]         fp_rf_addr,
    output logic [FLEN-1:0]    fp_rf_data,
    output logic               csr_trap_req,
    output logic               csr_trap_return_req,
    output logic [XLEN-1:0]    csr_trap_pc,
    output logic               csr_trap_is_interrupt,
    output logic [CAUSE_W-1:0] csr_trap_code,
    output logic [XLEN-1:0]    csr_trap_value,
    output logic               stall_req,
    output logic               flush_req,
    output logic [XLEN-1:0]    flush_target,
    output logic [63:0]        retired_count
);
    typedef enum logic [1:0] {NORMAL, TRAP_REQ, RET_REQ, FLUSH} state_t;
    state_t state, state_n;
    logic accept, take_trap, take_ret, retire, acked, unused;
    assign unused    = ^in_insn;
    assign accept    = state == NORMAL && in_valid;
    assign take_trap = accept && in_trap_valid;
    assign take_ret  = accept && !in_trap_valid && in_trap_return;
    assign retire    = accept && !in_trap_valid && !in_trap_return;
    assign acked     = (state == TRAP_REQ || state == RET_REQ) && csr_trap_ack;
    always_comb begin
        state_n = take_trap ? TRAP_REQ : take_ret ? RET_REQ : acked ? FLUSH : state == FLUSH ? NORMAL : state;
    end
    always_ff @(posedge clk) begin
        state <= rst ? NORMAL : state_n;
    end
    assign csr_trap_req        = state == TRAP_REQ;
    assign csr_trap_return_req = state == RET_REQ;
    assign stall_req           = csr_trap_req || csr_trap_return_req;
    assign flush_req           = state == FLUSH;
    always_ff @(posedge clk) begin
        if (rst) begin
            int_rf_we             <= 1'b0;
            int_rf_addr           <= '0;
            int_rf_data           <= '0;
            fp_rf_we              <= 1'b0;
            fp_rf_addr            <= '0;
            fp_rf_data            <= '0;
            csr_trap_pc           <= '0;
            csr_trap_is_interrupt <= 1'b0;
            csr_trap_code         <= '0;
            csr_trap_value        <= '0;
            flush_target          <= '0;
            retired_count         <= '0;
        end else begin
            int_rf_we <= retire && in_int_we && in_rd != 5'd0;
            fp_rf_we  <= retire && in_fp_we;
            if (retire) begin
                int_rf_addr <= in_rd;
                int_rf_data <= in_int_value;
                fp_rf_addr  <= in_rd;
                fp_rf_data  <= in_fp_value;
            end
            if (retire || take_ret) retired_count <= retired_count + 64'd1;
            if (take_trap || take_ret) csr_trap_pc <= in_pc;
            if (take_trap) begin
                csr_trap_is_interrupt <= in_trap_is_interrupt;
                csr_trap_code         <= in_trap_code;
                csr_trap_value        <= in_trap_value;
            end
            if (acked) flush_target <= csr_trap_target;
        end
    end
endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- Final pipeline stage, directly downstream of the execute stage; consumes its pipeline register outputs.
- Retires instructions by writing the int and fp register files.
- Serialises trap entry and trap return with the CSR unit through a request/acknowledge handshake.
- Maintains the retired-instruction counter and requests a pipeline stall/flush while a trap is being taken.

Parameters:
- XLEN, 32, integer register / pc width.
- FLEN, 64, fp register width.
- CAUSE_W, 5, exception/interrupt code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute stage result valid
- in_pc  in  XLEN  pc of instruction
- in_insn  in  32  raw instruction bits
- in_rd  in  5  destination register index
- in_int_we  in  1  int register write requested
- in_int_value  in  XLEN  int write data
- in_fp_we  in  1  fp register write requested
- in_fp_value  in  FLEN  fp write data
- in_trap_valid  in  1  instruction raised a trap
- in_trap_is_interrupt  in  1  trap cause interrupt bit
- in_trap_code  in  CAUSE_W  trap cause code
- in_trap_value  in  XLEN  trap value (tval)
- in_trap_return  in  1  instruction is xRET
- csr_trap_ack  in  1  CSR accepted trap/return request
- csr_trap_target  in  XLEN  handler or return pc from CSR
- int_rf_we  out  1  int register file write enable
- int_rf_addr  out  5  int write index
- int_rf_data  out  XLEN  int write data
- fp_rf_we  out  1  fp register file write enable
- fp_rf_addr  out  5  fp write index
- fp_rf_data  out  FLEN  fp write data
- csr_trap_req  out  1  trap entry request
- csr_trap_return_req  out  1  trap return request
- csr_trap_pc  out  XLEN  latched pc (epc)
- csr_trap_is_interrupt  out  1  latched cause interrupt bit
- csr_trap_code  out  CAUSE_W  latched cause code
- csr_trap_value  out  XLEN  latched tval
- stall_req  out  1  stall upstream stages
- flush_req  out  1  one-cycle pipeline flush
- flush_target  out  XLEN  redirect pc
- retired_count  out  64  retired instruction counter

Behaviour:
- Reset: all outputs 0; FSM = NORMAL; latched trap fields 0. Reset mid-handshake aborts the request (no req on the next cycle).
- FSM states: NORMAL, TRAP_REQ, RET_REQ, FLUSH.
- NORMAL with in_valid=1, in_trap_valid=0, in_trap_return=0 (retire):
  - next cycle int_rf_we = in_int_we and rd≠0, with int_rf_addr/data registered from inputs.
  - fp_rf_we = in_fp_we (x0 rule not applied to fp).
  - retired_count increments by 1 in the same clock edge; 1-cycle latency.
- NORMAL with in_valid=1, in_trap_valid=1:
  - no RF write, no retire count.
  - latch pc/cause/value; next state TRAP_REQ.
  - in_trap_valid has priority over in_trap_return.
- NORMAL with in_valid=1, in_trap_return=1, in_trap_valid=0:
  - xRET counts as retired; no RF write.
  - latch pc; next state RET_REQ.
- TRAP_REQ / RET_REQ:
  - csr_trap_req (resp. csr_trap_return_req) =1 and stall_req=1 held every cycle until csr_trap_ack sampled 1.
  - Latched csr_trap_* fields are stable while req is high.
  - Inputs are ignored in these states.
  - On ack: latch csr_trap_target; next state FLUSH.
  - Ack arriving in the same cycle the req first rises is legal (minimum 1-cycle request).
- FLUSH:
  - flush_req=1 for exactly one cycle, flush_target = latched target, stall_req=0.
  - in_valid is ignored this cycle (the instruction is squashed).
  - Next state NORMAL.
- csr_trap_ack outside TRAP_REQ/RET_REQ is ignored.
- retired_count wraps from 2^64-1 to 0.
- stall_req is a registered output (asserted the cycle after the trap instruction arrives).
- Upstream must not present a new valid instruction while stall_req=1.

Test Plan:
- Reset, then in_valid=1, in_int_we=1, rd=5, value=0xDEADBEEF -> next cycle int_rf_we=1, addr=5, data=0xDEADBEEF; retired_count=1.
- Write to rd=0 with in_int_we=1 -> int_rf_we stays 0; retired_count still increments.
- Fp write rd=3, value=0xFFFFFFFF_3F800000 -> fp_rf_we=1, fp_rf_addr=3, data matches; no int write.
- Trap: pc=0x100, code=2, value=insn, ack held low 3 cycles, then target=0x8000_0000:
  - csr_trap_req high 4 cycles with stable fields; stall_req high throughout.
  - then flush_req=1 for one cycle with flush_target=0x8000_0000.
  - retired_count unchanged.
- xRET at pc=0x200 with same-cycle ack, target=0x104:
  - csr_trap_return_req high 1 cycle, then flush to 0x104.
  - retired_count +1.
- Assert rst while in TRAP_REQ -> the next cycle all outputs are 0, FSM is NORMAL, and a later retire works normally. Separately, preload the counter to 2^64-1 and retire one instruction -> retired_count=0.
